// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The length check lives here so the FSM and anything else agree on the capacity rule.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [15:0] len_t;

  // True when a word count cannot fit in a memory of 2^addr_w words.
  function automatic logic len_too_big(len_t n, int unsigned addr_w);
    return 32'(n) > (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, control and instruction-memory write signals of the loader.
// master = stream source / boot controller side, slave = the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);

  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              done;
  logic              error;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_run, done, error
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_run, done, error
  );

endinterface

// File: rtl/be_word_packer.sv
// Big-endian byte-to-word assembler: the first byte of a word lands in bits [31:24].
// word_valid_o is asserted in the same cycle the 4th byte is presented.
module be_word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  assign shift_d = {shift_q[15:0], byte_i};
  assign cnt_d   = cnt_q + 2'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      cnt_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_valid_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checked byte frame, writes the words
// sequentially into instruction memory and releases the core only after verification.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  state_e            state_q;
  len_t              len_q;
  len_t              len_d;
  len_t              word_idx_q;
  logic [7:0]        acc_q;
  logic              in_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              cpu_run_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic              start_take;
  logic              last_word;
  logic              word_valid;
  logic [31:0]       word;

  assign accept     = bus.in_valid && in_ready_q;
  assign start_take = bus.start && (state_q inside {IDLE, DONE, ERROR});
  assign len_d      = {len_q[15:8], bus.in_data};
  assign last_word  = (word_idx_q + 16'd1) == len_q;

  be_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start_take),
    .byte_valid_i (accept && (state_q == DATA)),
    .byte_i       (bus.in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      acc_q        <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_run_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      // Address and data hold after the strobe so the memory side may sample late.
      if (word_valid) begin
        imem_we_q    <= 1'b1;
        imem_addr_q  <= word_idx_q[ADDR_W-1:0];
        imem_wdata_q <= word;
        word_idx_q   <= word_idx_q + 16'd1;
      end

      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            state_q    <= LEN_HI;
            in_ready_q <= 1'b1;
            cpu_run_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            acc_q      <= '0;
            word_idx_q <= '0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_q[15:8] <= bus.in_data;
            acc_q       <= acc_q ^ bus.in_data;
            state_q     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_q <= len_d;
            acc_q <= acc_q ^ bus.in_data;
            if (len_too_big(len_d, ADDR_W)) begin
              state_q    <= ERROR;
              in_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end else if (len_d == '0) begin
              state_q <= CHECK;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            acc_q <= acc_q ^ bus.in_data;
            if (word_valid && last_word) state_q <= CHECK;
          end
        end
        CHECK: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (bus.in_data == acc_q) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              cpu_run_q <= 1'b1;
            end else begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_run    = cpu_run_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are parsed by a byte-level reference model
// that predicts the write sequence and the verdict; writes are captured on the falling edge.
module tb_imem_loader;

  localparam int AW  = 6;
  localparam int CAP = 1 << AW;

  typedef logic [AW+31:0] wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fails  = 0;
  wr_t got_q[$];
  wr_t exp_q[$];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) got_q.push_back({bus.imem_addr, bus.imem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: parse the frame by its rules and predict writes and the verdict.
  function automatic void model(input logic [7:0] f[$], output int consumed,
                                output logic exp_done);
    int          n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_q.delete();
    n        = int'({f[0], f[1]});
    x        = f[0] ^ f[1];
    consumed = 2;
    exp_done = 1'b0;
    if (n > CAP) return;
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int b = 0; b < 4; b++) begin
        w = {w[23:0], f[2 + 4*i + b]};
        x = x ^ f[2 + 4*i + b];
      end
      exp_q.push_back({AW'(i), w});
    end
    consumed = 3 + 4*n;
    exp_done = (f[2 + 4*n] == x);
  endfunction

  function automatic void build_frame(input int n, input bit bad, output logic [7:0] f[$]);
    logic [7:0]  x;
    logic [31:0] w;
    f.delete();
    f.push_back(n[15:8]);
    f.push_back(n[7:0]);
    if (n > CAP) return;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) f.push_back(w[31-8*b -: 8]);
    end
    x = '0;
    foreach (f[i]) x = x ^ f[i];
    if (bad) x = x ^ (8'h01 << $urandom_range(7, 0));
    f.push_back(x);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   bus.in_ready,   0);
    check({tag, "_imem_we"},    bus.imem_we,    0);
    check({tag, "_imem_addr"},  bus.imem_addr,  0);
    check({tag, "_imem_wdata"}, bus.imem_wdata, 0);
    check({tag, "_cpu_run"},    bus.cpu_run,    0);
    check({tag, "_done"},       bus.done,       0);
    check({tag, "_error"},      bus.error,      0);
  endtask

  // junk: present a byte together with start; it must not be consumed.
  task automatic pulse_start(input string tag, input bit junk);
    @(negedge clk);
    bus.start = 1'b1;
    if (junk) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check({tag, "_start_in_ready"}, bus.in_ready, 1);
    check({tag, "_start_cpu_run"},  bus.cpu_run,  0);
    check({tag, "_start_done"},     bus.done,     0);
    check({tag, "_start_error"},    bus.error,    0);
  endtask

  task automatic send_bytes(input string tag, input logic [7:0] f[$], input int count,
                            input int gap_pct);
    int i      = 0;
    int waited = 0;
    while (i < count) begin
      @(negedge clk);
      if (waited > 100 * count + 100) begin
        check({tag, "_bytes_accepted"}, i, count);
        bus.in_valid = 1'b0;
        return;
      end
      waited++;
      if (int'($urandom_range(99, 0)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = f[i];
        if (bus.in_ready === 1'b1) i++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_write_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_write%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] f[$], input int gap_pct,
                           input bit junk);
    int   consumed;
    logic exp_done;
    model(f, consumed, exp_done);
    got_q.delete();
    pulse_start(tag, junk);
    send_bytes(tag, f, consumed, gap_pct);
    check({tag, "_done"},     bus.done,     exp_done);
    check({tag, "_error"},    bus.error,    !exp_done);
    check({tag, "_cpu_run"},  bus.cpu_run,  exp_done);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    repeat (3) @(negedge clk);
    compare_writes(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] good[$];
    int         n;
    int         consumed;
    logic       exp_done;

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset held with random inputs.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.start    = $urandom;
      bus.in_valid = $urandom;
      bus.in_data  = $urandom;
      #1 check_reset_outputs("reset");
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    check("reset_no_writes", got_q.size(), 0);

    // Directed good image; the byte offered with start in IDLE must be ignored.
    good = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
    run_frame("good", good, 0, 1'b1);
    if (got_q.size() == 2) begin
      check("good_word0", got_q[0], {6'd0, 32'h20080005});
      check("good_word1", got_q[1], {6'd1, 32'h2009000A});
    end

    f     = good;
    f[10] = 8'h0D;
    run_frame("badchk", f, 0, 1'b0);

    f = '{8'h00, 8'h41};
    run_frame("overflow", f, 0, 1'b0);

    f = '{8'h00, 8'h00, 8'h00};
    run_frame("empty", f, 0, 1'b0);

    run_frame("gaps", good, 40, 1'b0);

    // Random frames: lengths across the legal range, overflow and empty; random corruption.
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(9, 0))
        0:       n = 0;
        1:       n = CAP + int'($urandom_range(3, 1));
        2:       n = CAP;
        default: n = int'($urandom_range(CAP - 1, 1));
      endcase
      build_frame(n, ($urandom_range(3, 0) == 0), f);
      run_frame($sformatf("rand%0d", it), f, int'($urandom_range(60, 0)), 1'b0);
    end

    // Full-capacity image: last write must hit the all-ones address.
    build_frame(CAP, 1'b0, f);
    run_frame("full", f, 10, 1'b0);
    if (got_q.size() > 0) check("full_last_addr", got_q[got_q.size()-1][AW+31:32], CAP - 1);

    // Reset mid-load after word 0 has been written.
    model(good, consumed, exp_done);
    got_q.delete();
    pulse_start("midrst", 1'b0);
    send_bytes("midrst", good, 6, 0);
    repeat (2) @(negedge clk);
    check("midrst_writes_before", got_q.size(), 1);
    if (got_q.size() > 0) check("midrst_word0", got_q[0], exp_q[0]);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      check("midrst_hold_in_ready", bus.in_ready, 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrst_needs_start", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    check("midrst_writes_after", got_q.size(), 1);
    run_frame("after_rst", good, 20, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
